// File: rtl/uart_host_bridge.sv
// UART host bridge: AXI-Stream packets to and from 8N1 UART frames.
// On the wire packets travel most-significant byte first, and each byte is sent LSB first.
module uart_host_bridge #(
   parameter real         CLK_FREQ  = 1.0e6,
   parameter int unsigned BAUD_RATE = 115_200,
   parameter int unsigned S_WIDTH   = 12,
   parameter int unsigned M_WIDTH   = 12
) (
   input  logic               clk,
   input  logic               arstn,
   input  logic [S_WIDTH-1:0] s_axis_tdata,
   input  logic               s_axis_tvalid,
   output logic               s_axis_tready,
   output logic [M_WIDTH-1:0] m_axis_tdata,
   output logic               m_axis_tvalid,
   input  logic               m_axis_tready,
   input  logic               rxd,
   output logic               txd,
   output logic               tx_busy,
   output logic               rx_busy,
   output logic               rx_error
);
   localparam int BIT_CLKS = $rtoi(CLK_FREQ / real'(BAUD_RATE));
   localparam int HALF     = BIT_CLKS / 2;
   localparam int TW       = $clog2(BIT_CLKS);
   localparam int S_BYTES  = (S_WIDTH + 7) / 8;
   localparam int M_BYTES  = (M_WIDTH + 7) / 8;
   localparam int SB       = S_BYTES * 8;
   localparam int MB       = M_BYTES * 8;
   localparam int SCW      = $clog2(S_BYTES + 1);
   localparam int MCW      = $clog2(M_BYTES + 1);

   if (BIT_CLKS < 4) begin : g_bit_clks_check
      $error("uart_host_bridge: CLK_FREQ/BAUD_RATE must be at least 4");
   end

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   // ---------------- TX path ----------------
   state_e         tx_state_q;
   logic [TW-1:0]  tx_timer_q;
   logic [2:0]     tx_bit_q;
   logic [7:0]     tx_byte_q;
   logic [SB-1:0]  tx_shift_q;
   logic [SCW-1:0] tx_left_q;
   logic           txd_q, tx_ready_q, tx_busy_q;
   logic [SB-1:0]  tx_pad;
   logic           tx_tick;

   assign tx_pad  = SB'(s_axis_tdata);
   assign tx_tick = (tx_timer_q == TW'(BIT_CLKS - 1));

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         tx_state_q <= StIdle;
         tx_timer_q <= '0;
         tx_bit_q   <= '0;
         tx_byte_q  <= '0;
         tx_shift_q <= '0;
         tx_left_q  <= '0;
         txd_q      <= 1'b1;
         tx_ready_q <= 1'b1;
         tx_busy_q  <= 1'b0;
      end else begin
         tx_timer_q <= (tx_state_q == StIdle || tx_tick) ? '0 : tx_timer_q + 1'b1;
         unique case (tx_state_q)
            StIdle: begin
               if (s_axis_tvalid && tx_ready_q) begin
                  tx_byte_q  <= tx_pad[SB-1 -: 8];
                  tx_shift_q <= tx_pad << 8;
                  tx_left_q  <= SCW'(S_BYTES - 1);
                  txd_q      <= 1'b0;
                  tx_ready_q <= 1'b0;
                  tx_busy_q  <= 1'b1;
                  tx_state_q <= StStart;
               end
            end
            StStart: begin
               if (tx_tick) begin
                  txd_q      <= tx_byte_q[0];
                  tx_byte_q  <= tx_byte_q >> 1;
                  tx_bit_q   <= '0;
                  tx_state_q <= StData;
               end
            end
            StData: begin
               if (tx_tick) begin
                  if (tx_bit_q == 3'd7) begin
                     txd_q      <= 1'b1;
                     tx_state_q <= StStop;
                  end else begin
                     txd_q     <= tx_byte_q[0];
                     tx_byte_q <= tx_byte_q >> 1;
                     tx_bit_q  <= tx_bit_q + 3'd1;
                  end
               end
            end
            StStop: begin
               if (tx_tick) begin
                  // Next byte follows the stop bit directly; no idle gap inside a packet.
                  if (tx_left_q != '0) begin
                     tx_byte_q  <= tx_shift_q[SB-1 -: 8];
                     tx_shift_q <= tx_shift_q << 8;
                     tx_left_q  <= tx_left_q - 1'b1;
                     txd_q      <= 1'b0;
                     tx_state_q <= StStart;
                  end else begin
                     tx_busy_q  <= 1'b0;
                     tx_ready_q <= 1'b1;
                     tx_state_q <= StIdle;
                  end
               end
            end
            default: tx_state_q <= StIdle;
         endcase
      end
   end

   assign txd           = txd_q;
   assign s_axis_tready = tx_ready_q;
   assign tx_busy       = tx_busy_q;

   // ---------------- RX path ----------------
   state_e               rx_state_q;
   logic [1:0]           rx_sync_q;
   logic                 rx_prev_q;
   logic [TW-1:0]        rx_timer_q;
   logic [2:0]           rx_bit_q;
   logic [7:0]           rx_byte_q;
   logic [MB-1:0]        rx_asm_q;
   logic [MCW-1:0]       rx_cnt_q;
   logic                 rx_ferr_q, rx_busy_q, rx_err_q, m_valid_q;
   logic [M_WIDTH-1:0]   m_data_q;
   logic                 rxd_s, rx_tick, rx_half;
   logic [MB-1:0]        rx_asm_next;

   assign rxd_s       = rx_sync_q[1];
   assign rx_tick     = (rx_timer_q == TW'(BIT_CLKS - 1));
   assign rx_half     = (rx_timer_q == TW'(HALF - 1));
   assign rx_asm_next = (rx_asm_q << 8) | MB'(rx_byte_q);

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         rx_state_q <= StIdle;
         rx_sync_q  <= 2'b11;
         rx_prev_q  <= 1'b1;
         rx_timer_q <= '0;
         rx_bit_q   <= '0;
         rx_byte_q  <= '0;
         rx_asm_q   <= '0;
         rx_cnt_q   <= '0;
         rx_ferr_q  <= 1'b0;
         rx_busy_q  <= 1'b0;
         rx_err_q   <= 1'b0;
         m_valid_q  <= 1'b0;
         m_data_q   <= '0;
      end else begin
         rx_sync_q  <= {rx_sync_q[0], rxd};
         rx_prev_q  <= rxd_s;
         rx_timer_q <= rx_timer_q + 1'b1;
         if (m_valid_q && m_axis_tready) m_valid_q <= 1'b0;
         unique case (rx_state_q)
            StIdle: begin
               rx_timer_q <= '0;
               if (rx_prev_q && !rxd_s) begin
                  rx_busy_q  <= 1'b1;
                  rx_state_q <= StStart;
               end
            end
            StStart: begin
               if (rx_half) begin
                  rx_timer_q <= '0;
                  rx_bit_q   <= '0;
                  if (rxd_s) begin
                     rx_busy_q  <= 1'b0;
                     rx_state_q <= StIdle;
                  end else begin
                     rx_state_q <= StData;
                  end
               end
            end
            StData: begin
               if (rx_tick) begin
                  rx_timer_q <= '0;
                  rx_byte_q  <= {rxd_s, rx_byte_q[7:1]};
                  rx_bit_q   <= rx_bit_q + 3'd1;
                  if (rx_bit_q == 3'd7) rx_state_q <= StStop;
               end
            end
            StStop: begin
               if (rx_ferr_q) begin
                  // Bad stop bit: hold here until the line returns high.
                  if (rxd_s) begin
                     rx_ferr_q  <= 1'b0;
                     rx_busy_q  <= 1'b0;
                     rx_state_q <= StIdle;
                  end
               end else if (rx_tick) begin
                  rx_timer_q <= '0;
                  if (rxd_s) begin
                     rx_asm_q   <= rx_asm_next;
                     rx_busy_q  <= 1'b0;
                     rx_state_q <= StIdle;
                     if (rx_cnt_q == MCW'(M_BYTES - 1)) begin
                        rx_cnt_q <= '0;
                        if (!m_valid_q || m_axis_tready) begin
                           m_valid_q <= 1'b1;
                           m_data_q  <= rx_asm_next[M_WIDTH-1:0];
                        end else begin
                           rx_err_q <= 1'b1;
                        end
                     end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                     end
                  end else begin
                     rx_err_q  <= 1'b1;
                     rx_cnt_q  <= '0;
                     rx_ferr_q <= 1'b1;
                  end
               end
            end
            default: rx_state_q <= StIdle;
         endcase
      end
   end

   assign m_axis_tdata  = m_data_q;
   assign m_axis_tvalid = m_valid_q;
   assign rx_busy       = rx_busy_q;
   assign rx_error      = rx_err_q;

endmodule

// File: tb/tb_uart_host_bridge.sv
// Randomized scoreboard bench for uart_host_bridge: TX wire decoder, RX packet monitor.
module tb_uart_host_bridge;
   localparam int BC      = 10;
   localparam int W       = 12;
   localparam int S_BYTES = 2;

   logic          clk = 1'b0;
   logic          arstn = 1'b0;
   logic [W-1:0]  s_tdata = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tready;
   logic [W-1:0]  m_tdata;
   logic          m_tvalid;
   logic          m_tready = 1'b1;
   logic          rxd, txd, tx_busy, rx_busy, rx_error;
   logic          loop_en = 1'b0;
   logic          rxd_drv = 1'b1;

   assign rxd = loop_en ? txd : rxd_drv;

   uart_host_bridge #(
      .CLK_FREQ (1.0e6),
      .BAUD_RATE(100_000),
      .S_WIDTH  (W),
      .M_WIDTH  (W)
   ) dut (
      .clk          (clk),
      .arstn        (arstn),
      .s_axis_tdata (s_tdata),
      .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready),
      .m_axis_tdata (m_tdata),
      .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready),
      .rxd          (rxd),
      .txd          (txd),
      .tx_busy      (tx_busy),
      .rx_busy      (rx_busy),
      .rx_error     (rx_error)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int rx_hs = 0;
   int busy_cnt = 0;
   logic [7:0]   exp_tx_q[$];
   logic [W-1:0] exp_rx_q[$];

   function automatic void check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a packet is its zero-padded bytes, most significant first.
   task automatic push_tx_bytes(input logic [W-1:0] p);
      int v;
      v = int'(p);
      for (int i = S_BYTES - 1; i >= 0; i--) exp_tx_q.push_back(8'((v >> (8 * i)) & 'hff));
   endtask

   task automatic tx_send(input logic [W-1:0] p, input bit to_rx);
      int n;
      step();
      s_tdata  = p;
      s_tvalid = 1'b1;
      push_tx_bytes(p);
      if (to_rx) exp_rx_q.push_back(p);
      n = 0;
      while (!s_tready && n < 1000) begin
         step();
         n++;
      end
      check("tx_accept_timeout", n < 1000, 1);
      step();
      s_tvalid = 1'b0;
      check("tx_tready_drop", s_tready, 0);
      check("tx_busy_rise", tx_busy, 1);
   endtask

   task automatic tx_wait_idle();
      int n;
      n = 0;
      while ((tx_busy || exp_tx_q.size() != 0) && n < 2000) begin
         step();
         n++;
      end
      check("tx_idle_timeout", n < 2000, 1);
      check("tx_tready_after", s_tready, 1);
   endtask

   task automatic rx_byte(input logic [7:0] b, input logic stop);
      rxd_drv = 1'b0;
      repeat (BC) step();
      for (int i = 0; i < 8; i++) begin
         rxd_drv = b[i];
         repeat (BC) step();
      end
      rxd_drv = stop;
      repeat (BC) step();
      rxd_drv = 1'b1;
      repeat (6) step();
   endtask

   task automatic rx_drain();
      int n;
      n = 0;
      while (exp_rx_q.size() != 0 && n < 3000) begin
         step();
         n++;
      end
      check("rx_drain_left", exp_rx_q.size(), 0);
   endtask

   task automatic do_reset();
      arstn = 1'b0;
      repeat (3) step();
      arstn = 1'b1;
      step();
   endtask

   // RX monitor: every handshake pops the scoreboard.
   always @(negedge clk) begin
      if (arstn && m_tvalid && m_tready) begin
         rx_hs++;
         if (exp_rx_q.size() == 0) check("rx_unexpected_pkt", exp_rx_q.size(), 1);
         else check("rx_data", m_tdata, exp_rx_q.pop_front());
      end
   end

   // Busy-length monitor: every completed packet occupies exactly S_BYTES*10*BC cycles.
   always @(negedge clk) begin
      if (!arstn) busy_cnt = 0;
      else if (tx_busy) busy_cnt++;
      else if (busy_cnt != 0) begin
         check("tx_busy_len", busy_cnt, S_BYTES * 10 * BC);
         busy_cnt = 0;
      end
   end

   // TX wire decoder: samples mid-bit after each falling edge.
   initial begin : tx_mon
      logic       prev, st, sp;
      logic [7:0] b;
      bit         ab;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (arstn && prev && !txd) begin
            ab = !arstn;
            repeat (BC / 2) begin
               @(negedge clk);
               if (!arstn) ab = 1'b1;
            end
            st = txd;
            for (int i = 0; i < 8; i++) begin
               repeat (BC) begin
                  @(negedge clk);
                  if (!arstn) ab = 1'b1;
               end
               b[i] = txd;
            end
            repeat (BC) begin
               @(negedge clk);
               if (!arstn) ab = 1'b1;
            end
            sp = txd;
            if (!ab) begin
               check("tx_start_bit", st, 0);
               check("tx_stop_bit", sp, 1);
               if (exp_tx_q.size() == 0) check("tx_unexpected_byte", exp_tx_q.size(), 1);
               else check("tx_byte", b, exp_tx_q.pop_front());
            end
         end
         prev = txd;
      end
   end

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      int h0, lows;
      bit seen;
      logic [W-1:0] p;

      repeat (2) step();
      check("rst_txd", txd, 1);
      check("rst_tready", s_tready, 1);
      check("rst_tx_busy", tx_busy, 0);
      check("rst_m_tvalid", m_tvalid, 0);
      check("rst_m_tdata", m_tdata, 0);
      check("rst_rx_busy", rx_busy, 0);
      check("rst_rx_error", rx_error, 0);
      arstn = 1'b1;
      step();

      // TX framing of 0xABC.
      tx_send(12'hABC, 1'b0);
      tx_wait_idle();

      // Loopback, back-to-back, fixed then random packets.
      loop_en = 1'b1;
      tx_send(12'h123, 1'b1);
      tx_send(12'hFFF, 1'b1);
      tx_send(12'h000, 1'b1);
      for (int i = 0; i < 6; i++) begin
         p = W'($urandom_range(0, 4095));
         tx_send(p, 1'b1);
      end
      tx_wait_idle();
      rx_drain();
      check("loop_rx_error", rx_error, 0);
      loop_en = 1'b0;
      step();

      // Frame error then a good packet.
      do_reset();
      rx_byte(8'h33, 1'b0);
      exp_rx_q.push_back(12'h55A);
      rx_byte(8'h05, 1'b1);
      rx_byte(8'h5A, 1'b1);
      rx_drain();
      check("ferr_rx_error", rx_error, 1);

      // False start glitch.
      do_reset();
      h0 = rx_hs;
      rxd_drv = 1'b0;
      repeat (3) step();
      rxd_drv = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (rx_busy) seen = 1'b1;
         step();
      end
      check("false_start_busy_seen", seen, 1);
      check("false_start_busy_drop", rx_busy, 0);
      repeat (20) step();
      check("false_start_tvalid", m_tvalid, 0);
      check("false_start_hs", rx_hs - h0, 0);
      check("false_start_error", rx_error, 0);

      // Overrun with consumer stalled.
      do_reset();
      m_tready = 1'b0;
      h0 = rx_hs;
      exp_rx_q.push_back(12'h111);
      rx_byte(8'h01, 1'b1);
      rx_byte(8'h11, 1'b1);
      rx_byte(8'h02, 1'b1);
      rx_byte(8'h22, 1'b1);
      check("ovr_tvalid", m_tvalid, 1);
      check("ovr_tdata_held", m_tdata, 12'h111);
      check("ovr_rx_error", rx_error, 1);
      m_tready = 1'b1;
      repeat (20) step();
      check("ovr_handshakes", rx_hs - h0, 1);
      check("ovr_queue_empty", exp_rx_q.size(), 0);

      // Reset during the second TX byte's data bits.
      do_reset();
      tx_send(12'hABC, 1'b0);
      repeat (10 * BC + BC + 3 * BC) step();
      check("mid_tx_busy_before", tx_busy, 1);
      arstn = 1'b0;
      #1;
      check("mid_rst_txd", txd, 1);
      check("mid_rst_busy", tx_busy, 0);
      exp_tx_q.delete();
      repeat (3) step();
      arstn = 1'b1;
      step();
      check("mid_rst_tready", s_tready, 1);
      lows = 0;
      for (int i = 0; i < 300; i++) begin
         if (!txd || tx_busy) lows++;
         step();
      end
      check("mid_rst_no_residual", lows, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
